// File: rtl/amber_wb_feeder_pkg.sv
// Shared constants and types for the Amber instruction feeder.
// Holds the NOP word, queue geometry and the bus FSM state encoding.
package amber_feeder_pkg;

  localparam logic [31:0] NOP_INST   = 32'hF0801003;
  localparam int          FIFO_DEPTH = 8;
  localparam int          INST_W     = 32;
  localparam int          LEVEL_W    = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } fsm_state_t;

  // Lane 0 carries the fetched word; the upper lanes are padded with NOPs.
  function automatic logic [127:0] nop_fill(input logic [31:0] lane0);
    return {NOP_INST, NOP_INST, NOP_INST, lane0};
  endfunction

endpackage

// File: rtl/amber_wb_feeder_if.sv
// 128-bit Wishbone link between the Amber core (master) and the feeder.
// Signal names follow the feeder's external naming.
interface amber_wb_feeder_if;

  logic [31:0]  i_wb_adr;
  logic [15:0]  i_wb_sel;
  logic         i_wb_we;
  logic [127:0] i_wb_dat;
  logic         i_wb_cyc;
  logic         i_wb_stb;
  logic [127:0] o_wb_dat;
  logic         o_wb_ack;
  logic         o_wb_err;

  modport master (
    output i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat,
    output i_wb_cyc, i_wb_stb,
    input  o_wb_dat, o_wb_ack, o_wb_err
  );

  modport slave (
    input  i_wb_adr, i_wb_sel, i_wb_we, i_wb_dat,
    input  i_wb_cyc, i_wb_stb,
    output o_wb_dat, o_wb_ack, o_wb_err
  );

endinterface

// File: rtl/amber_wb_feeder_fifo.sv
// Instruction queue for the feeder: synchronous FIFO with level count.
// Push when full and pop when empty are ignored.
module amber_feeder_fifo
  import amber_feeder_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int WIDTH = INST_W
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic [WIDTH-1:0]             i_din,
  output logic [WIDTH-1:0]             o_dout,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    level;
  logic             push_ok;
  logic             pop_ok;

  assign o_full  = (level == LW'(DEPTH));
  assign o_empty = (level == '0);
  assign o_level = level;
  assign o_dout  = mem[rd_ptr];

  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= i_din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/amber_wb_feeder.sv
// Wishbone slave that feeds queued instructions to the Amber core.
// Define AMBER_FEEDER_WAIT_EN to add programmable wait states.
module amber_wb_feeder
  import amber_feeder_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic [31:0]   i_push_inst,
  output logic          o_full,
  output logic          o_empty,
  output logic [3:0]    o_level,
`ifdef AMBER_FEEDER_WAIT_EN
  input  logic [3:0]    i_wait_cycles,
`endif
  amber_wb_feeder_if.slave wb,
  output logic          o_store_valid,
  output logic [31:0]   o_store_adr,
  output logic [15:0]   o_store_sel,
  output logic [127:0]  o_store_dat,
  output logic [15:0]   o_fetch_count,
  output logic          o_underrun,
  output logic          o_overflow
);

  fsm_state_t   state;
  fsm_state_t   state_nx;
  logic [3:0]   wait_cnt;
  logic [3:0]   wait_ld;
  logic         req_we;
  logic         req_err;
  logic [127:0] pend_dat;
  logic [127:0] wb_dat_q;
  logic [127:0] rd_word;
  logic [31:0]  fifo_dout;
  logic         fifo_full;
  logic         fifo_empty;
  logic         accept;
  logic         pop;
  logic         enter_ack;
  logic         ack_rd;
  logic         ack_c;
  logic         err_c;
  logic         sv_c;

`ifdef AMBER_FEEDER_WAIT_EN
  assign wait_ld = i_wait_cycles;
`else
  assign wait_ld = 4'd0;
`endif

  amber_feeder_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (INST_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_push),
    .i_pop   (pop),
    .i_din   (i_push_inst),
    .o_dout  (fifo_dout),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (o_level)
  );

  assign o_full  = fifo_full;
  assign o_empty = fifo_empty;

  assign accept = (state == ST_IDLE) && wb.i_wb_cyc && wb.i_wb_stb;
  assign pop    = accept && !wb.i_wb_we && !fifo_empty;
  assign rd_word = fifo_empty ? nop_fill(NOP_INST) : nop_fill(fifo_dout);

  // A read reaches ACK either straight from IDLE or after its wait states.
  assign enter_ack = (state_nx == ST_ACK) && (state != ST_ACK);
  assign ack_rd    = enter_ack &&
                     ((state == ST_IDLE) ? !wb.i_wb_we : !req_we);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx = (wait_ld != 4'd0) ? ST_WAIT : ST_ACK;
        end
      end
      ST_WAIT: begin
        if (!wb.i_wb_cyc)          state_nx = ST_IDLE;
        else if (wait_cnt <= 4'd1) state_nx = ST_ACK;
      end
      ST_ACK:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    ack_c = 1'b0;
    err_c = 1'b0;
    sv_c  = 1'b0;
    if (state == ST_ACK) begin
      ack_c = !req_err;
      err_c = req_err;
      sv_c  = req_we && !req_err;
    end
  end

  assign wb.o_wb_ack = ack_c;
  assign wb.o_wb_err = err_c;
  assign wb.o_wb_dat = wb_dat_q;
  assign o_store_valid = sv_c;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wait_cnt      <= 4'd0;
      req_we        <= 1'b0;
      req_err       <= 1'b0;
      pend_dat      <= '0;
      wb_dat_q      <= '0;
      o_store_adr   <= '0;
      o_store_sel   <= '0;
      o_store_dat   <= '0;
      o_fetch_count <= '0;
      o_underrun    <= 1'b0;
      o_overflow    <= 1'b0;
    end else begin
      if (i_push && fifo_full) o_overflow <= 1'b1;
      if (accept) begin
        wait_cnt <= wait_ld;
        req_we   <= wb.i_wb_we;
        req_err  <= wb.i_wb_we && (wb.i_wb_sel == 16'd0);
        if (!wb.i_wb_we) begin
          pend_dat <= rd_word;
          if (fifo_empty) o_underrun <= 1'b1;
        end else if (wb.i_wb_sel != 16'd0) begin
          o_store_adr <= wb.i_wb_adr;
          o_store_sel <= wb.i_wb_sel;
          o_store_dat <= wb.i_wb_dat;
        end
      end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      // Read data only moves when the ack is about to be presented.
      if (ack_rd) begin
        wb_dat_q <= (state == ST_IDLE) ? rd_word : pend_dat;
        if (o_fetch_count != 16'hFFFF) begin
          o_fetch_count <= o_fetch_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_amber_wb_feeder.sv
// Self-checking bench for amber_wb_feeder: write vector table plus
// scoreboarded read sequences for queue order, underrun and abort cases.
module tb_amber_wb_feeder;

  localparam logic [31:0]  NOP   = 32'hF0801003;
  localparam logic [127:0] NOP4  = {NOP, NOP, NOP, NOP};

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_push = 1'b0;
  logic [31:0]  i_push_inst = '0;
  logic         o_full;
  logic         o_empty;
  logic [3:0]   o_level;
  logic [3:0]   wait_cfg = 4'd0;
  logic         o_store_valid;
  logic [31:0]  o_store_adr;
  logic [15:0]  o_store_sel;
  logic [127:0] o_store_dat;
  logic [15:0]  o_fetch_count;
  logic         o_underrun;
  logic         o_overflow;

  amber_wb_feeder_if wb();

  amber_wb_feeder dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_push        (i_push),
    .i_push_inst   (i_push_inst),
    .o_full        (o_full),
    .o_empty       (o_empty),
    .o_level       (o_level),
`ifdef AMBER_FEEDER_WAIT_EN
    .i_wait_cycles (wait_cfg),
`endif
    .wb            (wb),
    .o_store_valid (o_store_valid),
    .o_store_adr   (o_store_adr),
    .o_store_sel   (o_store_sel),
    .o_store_dat   (o_store_dat),
    .o_fetch_count (o_fetch_count),
    .o_underrun    (o_underrun),
    .o_overflow    (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0]  adr;
    logic [15:0]  sel;
    logic [127:0] dat;
    logic         exp_err;
  } wr_vec_t;

  int           vecs = 0;
  int           fails = 0;
  logic [31:0]  model_q[$];
  logic [15:0]  exp_fetch = 0;
  logic         exp_und = 0;
  logic         exp_ovf = 0;
  logic [127:0] exp_rdat = 0;
  logic [31:0]  exp_sadr = 0;
  logic [15:0]  exp_ssel = 0;
  logic [127:0] exp_sdat = 0;

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    vecs++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] v);
    i_push = 1'b1;
    i_push_inst = v;
    @(posedge i_clk); #1;
    i_push = 1'b0;
    if (model_q.size() < 8) model_q.push_back(v);
    else exp_ovf = 1'b1;
  endtask

  task automatic wb_bus(input logic we, input logic [31:0] adr,
                        input logic [15:0] sel, input logic [127:0] dat,
                        output int lat, output logic ack,
                        output logic err, output logic sv,
                        output logic [127:0] rdat);
    wb.i_wb_cyc = 1'b1;
    wb.i_wb_stb = 1'b1;
    wb.i_wb_we  = we;
    wb.i_wb_adr = adr;
    wb.i_wb_sel = sel;
    wb.i_wb_dat = dat;
    lat = 0; ack = 0; err = 0; sv = 0; rdat = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge i_clk); #1;
      if (wb.o_wb_ack || wb.o_wb_err) begin
        lat  = k;
        ack  = wb.o_wb_ack;
        err  = wb.o_wb_err;
        sv   = o_store_valid;
        rdat = wb.o_wb_dat;
        break;
      end
    end
    wb.i_wb_cyc = 1'b0;
    wb.i_wb_stb = 1'b0;
    wb.i_wb_we  = 1'b0;
    @(posedge i_clk); #1;
    chk("resp_one_cycle", {wb.o_wb_ack, wb.o_wb_err, o_store_valid},
        128'd0);
  endtask

  task automatic wb_read(input string nm);
    int lat; logic ack, err, sv; logic [127:0] rdat;
    if (model_q.size() > 0) begin
      exp_rdat = {NOP, NOP, NOP, model_q.pop_front()};
    end else begin
      exp_rdat = NOP4;
      exp_und  = 1'b1;
    end
    wb_bus(1'b0, 32'h0, 16'hFFFF, 128'h0, lat, ack, err, sv, rdat);
    exp_fetch++;
    chk({nm, "_lat"}, lat, 32'(wait_cfg) + 1);
    chk({nm, "_ack"}, {ack, err}, 2'b10);
    chk({nm, "_dat"}, rdat, exp_rdat);
    chk({nm, "_fetch"}, o_fetch_count, exp_fetch);
    chk({nm, "_und"}, o_underrun, exp_und);
    chk({nm, "_level"}, o_level, model_q.size());
  endtask

  wr_vec_t wv[4];

  initial begin
    int lat; logic ack, err, sv; logic [127:0] rdat;
    logic [31:0] w;

    wv[0] = '{32'h0000_0100, 16'h000F,
              128'hDEAD_BEEF_0000_0000_CAFE_F00D_0000_1234, 1'b0};
    wv[1] = '{32'h0000_0200, 16'h0000,
              128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b1};
    wv[2] = '{32'h0000_0304, 16'hFFFF,
              128'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F_F0F0_F0F0, 1'b0};
    wv[3] = '{32'hFFFF_FFF0, 16'h0000,
              128'h0, 1'b1};

    wb.i_wb_cyc = 1'b0;
    wb.i_wb_stb = 1'b0;
    wb.i_wb_we  = 1'b0;
    wb.i_wb_adr = '0;
    wb.i_wb_sel = '0;
    wb.i_wb_dat = '0;

    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    chk("rst_flags", {o_empty, o_full, o_level}, 6'b10_0000);
    chk("rst_resp", {wb.o_wb_ack, wb.o_wb_err, o_store_valid}, 0);
    chk("rst_stats", {o_fetch_count, o_underrun, o_overflow}, 0);
    chk("rst_wbdat", wb.o_wb_dat, 0);
    chk("rst_store", {o_store_adr, o_store_sel}, 0);

    push(32'hE0812003);
    wb_read("rd_one");

    wb_read("rd_empty");

    for (int i = 0; i < 9; i++) begin
      push(32'h1000_0000 + i);
      if (i == 6) chk("not_full_7", o_full, 1'b0);
      if (i == 7) chk("full_8", o_full, 1'b1);
    end
    chk("ovf_level", {o_overflow, o_level}, {exp_ovf, 4'd8});
    for (int i = 0; i < 8; i++) wb_read("rd_order");
    chk("drained", {o_empty, o_full}, 2'b10);

    for (int i = 0; i < 4; i++) begin
      wb_bus(1'b1, wv[i].adr, wv[i].sel, wv[i].dat,
             lat, ack, err, sv, rdat);
      if (!wv[i].exp_err) begin
        exp_sadr = wv[i].adr;
        exp_ssel = wv[i].sel;
        exp_sdat = wv[i].dat;
      end
      chk("wr_lat", lat, 32'(wait_cfg) + 1);
      chk("wr_resp", {ack, err, sv},
          {!wv[i].exp_err, wv[i].exp_err, !wv[i].exp_err});
      chk("wr_store", {o_store_adr, o_store_sel}, {exp_sadr, exp_ssel});
      chk("wr_sdat", o_store_dat, exp_sdat);
      chk("wr_hold_rdat", wb.o_wb_dat, exp_rdat);
    end

    push(32'hAAAA_0001);
    push(32'hAAAA_0002);
    exp_rdat = {NOP, NOP, NOP, model_q.pop_front()};
    model_q.push_back(32'hAAAA_0003);
    i_push = 1'b1;
    i_push_inst = 32'hAAAA_0003;
    wb.i_wb_cyc = 1'b1;
    wb.i_wb_stb = 1'b1;
    wb.i_wb_we  = 1'b0;
    @(posedge i_clk); #1;
    i_push = 1'b0;
    exp_fetch++;
    chk("pp_ack", wb.o_wb_ack, 1'b1);
    chk("pp_dat", wb.o_wb_dat, exp_rdat);
    chk("pp_level", o_level, 4'd2);
    wb.i_wb_cyc = 1'b0;
    wb.i_wb_stb = 1'b0;
    @(posedge i_clk); #1;
    wb_read("pp_rd1");
    wb_read("pp_rd2");

    exp_und = 1'b1;
    i_push = 1'b1;
    i_push_inst = 32'hBBBB_0001;
    wb.i_wb_cyc = 1'b1;
    wb.i_wb_stb = 1'b1;
    @(posedge i_clk); #1;
    i_push = 1'b0;
    exp_fetch++;
    model_q.push_back(32'hBBBB_0001);
    chk("ep_dat", wb.o_wb_dat, NOP4);
    chk("ep_level", o_level, 4'd1);
    wb.i_wb_cyc = 1'b0;
    wb.i_wb_stb = 1'b0;
    @(posedge i_clk); #1;
    exp_rdat = NOP4;
    wb_read("ep_rd");

`ifdef AMBER_FEEDER_WAIT_EN
    wait_cfg = 4'd3;
    push(32'hCCCC_0001);
    wb_read("wt_rd");
    push(32'hCCCC_0002);
    push(32'hCCCC_0003);
    void'(model_q.pop_front());
    wb.i_wb_cyc = 1'b1;
    wb.i_wb_stb = 1'b1;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    wb.i_wb_cyc = 1'b0;
    wb.i_wb_stb = 1'b0;
    w = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge i_clk); #1;
      if (wb.o_wb_ack || wb.o_wb_err) w = w + 1;
    end
    chk("abort_noack", w, 0);
    chk("abort_level", o_level, 4'd1);
    chk("abort_fetch", o_fetch_count, exp_fetch);
    wb_read("abort_next");
`endif

    push(32'hDDDD_0001);
    wb.i_wb_cyc = 1'b1;
    wb.i_wb_stb = 1'b1;
    @(posedge i_clk); #1;
    if (wait_cfg != 0) begin
      @(posedge i_clk); #1;
    end
    i_rst = 1'b1;
    wb.i_wb_cyc = 1'b0;
    wb.i_wb_stb = 1'b0;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    model_q.delete();
    exp_fetch = 0;
    exp_und = 0;
    exp_ovf = 0;
    chk("mrst_ack", {wb.o_wb_ack, wb.o_wb_err}, 0);
    chk("mrst_level", {o_level, o_empty}, {4'd0, 1'b1});
    chk("mrst_stats", {o_fetch_count, o_underrun, o_overflow}, 0);
    w = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge i_clk); #1;
      if (wb.o_wb_ack) w = w + 1;
    end
    chk("mrst_noack", w, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
